// File: rtl/term_pkg.sv
// Shared types and constants for the terminal mode register block: command codes,
// the fixed mode table, reset defaults and report status codes.
package term_pkg;

  typedef enum logic [3:0] {
    INIT_PN,
    EMIT_PN,
    SETMODE,
    RESETMODE,
    SETDEC,
    RESETDEC,
    SAVEDEC,
    RESTOREDEC,
    REQMODE,
    REQDEC
  } commands_type_e;

  localparam int unsigned MODE_TABLE_N = 8;

  // Entry i of the table owns bit i of the mode vector.
  localparam logic [7:0] MODE_PN [MODE_TABLE_N] = '{
    8'd6, 8'd7, 8'd12, 8'd25, 8'd4, 8'd20, 8'd5, 8'd1
  };
  localparam logic MODE_IS_DEC [MODE_TABLE_N] = '{
    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1
  };

  localparam logic [7:0] MODE_DEFAULT = 8'b0000_1110;

  localparam logic [1:0] RPT_NONE  = 2'd0;
  localparam logic [1:0] RPT_SET   = 2'd1;
  localparam logic [1:0] RPT_RESET = 2'd2;

  function automatic logic is_dec_cmd(commands_type_e c);
    return c inside {SETDEC, RESETDEC, SAVEDEC, RESTOREDEC, REQDEC};
  endfunction

endpackage

// File: rtl/term_mode_ctrl_if.sv
// Command/report bus between the CSI parser and the terminal mode register block.
interface term_mode_ctrl_if #(
  parameter int unsigned PN_W      = 8,
  parameter int unsigned NUM_MODES = 8
);

  logic                         cmd_valid;
  logic                         cmd_ready;
  term_pkg::commands_type_e     cmd_type;
  logic [PN_W-1:0]              pn;
  logic [NUM_MODES-1:0]         mode_o;
  logic                         pn_overflow;
  logic                         rpt_valid;
  logic                         rpt_ready;
  logic                         rpt_dec;
  logic [PN_W-1:0]              rpt_pn;
  logic [1:0]                   rpt_status;

  modport master (
    output cmd_valid, cmd_type, pn, rpt_ready,
    input  cmd_ready, mode_o, pn_overflow, rpt_valid, rpt_dec, rpt_pn, rpt_status
  );

  modport slave (
    input  cmd_valid, cmd_type, pn, rpt_ready,
    output cmd_ready, mode_o, pn_overflow, rpt_valid, rpt_dec, rpt_pn, rpt_status
  );

endinterface

// File: rtl/term_mode_decode.sv
// Combinational lookup of a (Pn, DEC/ANSI space) pair in the mode table.
module term_mode_decode
  import term_pkg::*;
#(
  parameter int unsigned PN_W      = 8,
  parameter int unsigned NUM_MODES = 8,
  localparam int unsigned IdxW     = $clog2(NUM_MODES)
) (
  input  logic [PN_W-1:0] pn,
  input  logic            is_dec,
  output logic            hit,
  output logic [IdxW-1:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (!hit && (MODE_IS_DEC[i] == is_dec) && (pn == PN_W'(MODE_PN[i]))) begin
        hit   = 1'b1;
        index = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/term_mode_ctrl.sv
// Terminal mode register block: buffers a Pn list, then applies set/reset,
// DEC save/restore or a mode report for it, one buffered Pn per cycle.
module term_mode_ctrl
  import term_pkg::*;
#(
  parameter int unsigned MAX_PARAMS = 8,
  parameter int unsigned NUM_MODES  = 8,
  parameter int unsigned PN_W       = 8
) (
  input logic             clk,
  input logic             rst,
  term_mode_ctrl_if.slave bus
);

  localparam int unsigned CntW  = $clog2(MAX_PARAMS + 1);
  localparam int unsigned BufIW = $clog2(MAX_PARAMS);
  localparam int unsigned MIdxW = $clog2(NUM_MODES);

  typedef enum logic [2:0] {StIdle, StApply, StSave, StRestore, StReport} state_e;

  state_e                 state_q;
  commands_type_e         cmd_q;
  logic [PN_W-1:0]        buf_q [MAX_PARAMS];
  logic [CntW-1:0]        count_q;
  logic [CntW-1:0]        idx_q;
  logic [NUM_MODES-1:0]   mode_q;
  logic [NUM_MODES-1:0]   save_q;
  logic                   overflow_q;
  logic                   rpt_valid_q;
  logic                   rpt_dec_q;
  logic [PN_W-1:0]        rpt_pn_q;
  logic [1:0]             rpt_status_q;

  logic                   hit;
  logic [MIdxW-1:0]       hit_idx;
  logic [NUM_MODES-1:0]   dec_mask;
  logic                   last;
  logic                   all_dec;

  term_mode_decode #(
    .PN_W      (PN_W),
    .NUM_MODES (NUM_MODES)
  ) u_decode (
    .pn     (buf_q[idx_q[BufIW-1:0]]),
    .is_dec (is_dec_cmd(cmd_q)),
    .hit    (hit),
    .index  (hit_idx)
  );

  always_comb begin
    dec_mask = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      dec_mask[i] = MODE_IS_DEC[i];
    end
  end

  assign last = (idx_q == count_q - CntW'(1));
  // A lone Pn 0 is the parser's empty list: save/restore covers every DEC mode.
  assign all_dec = (count_q == CntW'(1)) && (buf_q[0] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_q        <= INIT_PN;
      count_q      <= '0;
      idx_q        <= '0;
      mode_q       <= NUM_MODES'(MODE_DEFAULT);
      save_q       <= NUM_MODES'(MODE_DEFAULT);
      overflow_q   <= 1'b0;
      rpt_valid_q  <= 1'b0;
      rpt_dec_q    <= 1'b0;
      rpt_pn_q     <= '0;
      rpt_status_q <= RPT_NONE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_type == INIT_PN) begin
              count_q    <= '0;
              overflow_q <= 1'b0;
            end else begin
              if (count_q < CntW'(MAX_PARAMS)) begin
                buf_q[count_q[BufIW-1:0]] <= bus.pn;
                count_q                   <= count_q + CntW'(1);
              end else begin
                overflow_q <= 1'b1;
              end
              cmd_q <= bus.cmd_type;
              idx_q <= '0;
              case (bus.cmd_type)
                SETMODE, RESETMODE, SETDEC, RESETDEC: state_q <= StApply;
                SAVEDEC:                              state_q <= StSave;
                RESTOREDEC:                           state_q <= StRestore;
                REQMODE, REQDEC:                      state_q <= StReport;
                default:                              state_q <= StIdle;
              endcase
            end
          end
        end
        StApply, StSave, StRestore: begin
          if (state_q == StApply) begin
            if (hit) mode_q[hit_idx] <= (cmd_q inside {SETMODE, SETDEC});
          end else if (state_q == StSave) begin
            if (all_dec)  save_q <= (save_q & ~dec_mask) | (mode_q & dec_mask);
            else if (hit) save_q[hit_idx] <= mode_q[hit_idx];
          end else begin
            if (all_dec)  mode_q <= (mode_q & ~dec_mask) | (save_q & dec_mask);
            else if (hit) mode_q[hit_idx] <= save_q[hit_idx];
          end
          if (last) state_q <= StIdle;
          else      idx_q   <= idx_q + CntW'(1);
        end
        StReport: begin
          if (!rpt_valid_q) begin
            rpt_valid_q  <= 1'b1;
            rpt_dec_q    <= (cmd_q == REQDEC);
            rpt_pn_q     <= buf_q[0];
            rpt_status_q <= hit ? (mode_q[hit_idx] ? RPT_SET : RPT_RESET) : RPT_NONE;
          end else if (bus.rpt_ready) begin
            rpt_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == StIdle);
  assign bus.mode_o      = mode_q;
  assign bus.pn_overflow = overflow_q;
  assign bus.rpt_valid   = rpt_valid_q;
  assign bus.rpt_dec     = rpt_dec_q;
  assign bus.rpt_pn      = rpt_pn_q;
  assign bus.rpt_status  = rpt_status_q;

endmodule

// File: tb/tb_term_mode_ctrl.sv
// Directed and randomized checks of term_mode_ctrl against a list-level model of the
// mode table, save register and report rules.
module tb_term_mode_ctrl;
  import term_pkg::*;

  localparam int MAXP = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  term_mode_ctrl_if #(.PN_W(8), .NUM_MODES(8)) bus ();

  term_mode_ctrl #(
    .MAX_PARAMS (MAXP),
    .NUM_MODES  (8),
    .PN_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: the mode table as (Pn, is_dec) pairs, plus live and saved bits.
  int   tbl_pn  [8] = '{6, 7, 12, 25, 4, 20, 5, 1};
  bit   tbl_dec [8] = '{1, 1, 1, 1, 0, 0, 1, 1};
  logic [7:0] m_mode;
  logic [7:0] m_save;
  int   sq [$];

  function automatic int lookup(int p, bit dec);
    for (int i = 0; i < 8; i++) if (tbl_pn[i] == p && tbl_dec[i] == dec) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input commands_type_e t, input int p);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.pn        = 8'(p);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Sends INIT_PN, every Pn in sq but the last as EMIT_PN, then the final command
  // carrying the last Pn; checks timing and results against the model.
  task automatic run_seq(input commands_type_e t, input int hold);
    int  q [$];
    bit  ovf, dec, is_rpt;
    int  busy, ix, exp_status;
    dec    = (t inside {SETDEC, RESETDEC, SAVEDEC, RESTOREDEC, REQDEC});
    is_rpt = (t inside {REQMODE, REQDEC});
    send(INIT_PN, 0);
    for (int i = 0; i < sq.size() - 1; i++) send(EMIT_PN, sq[i]);
    if (is_rpt) bus.rpt_ready = (hold == 0);
    send(t, sq[sq.size()-1]);
    q.delete();
    for (int i = 0; i < sq.size() && i < MAXP; i++) q.push_back(sq[i]);
    ovf = (sq.size() > MAXP);
    if (is_rpt) begin
      ix = lookup(q[0], dec);
      exp_status = (ix < 0) ? 0 : (m_mode[ix] ? 1 : 2);
      chk("rpt_not_yet", {31'd0, bus.rpt_valid}, 32'd0);
      @(posedge clk); #1;
      chk("rpt_valid", {31'd0, bus.rpt_valid}, 32'd1);
      chk("rpt_dec", {31'd0, bus.rpt_dec}, {31'd0, dec});
      chk("rpt_pn", {24'd0, bus.rpt_pn}, 32'(q[0] & 8'hff));
      chk("rpt_status", {30'd0, bus.rpt_status}, 32'(exp_status));
      if (hold > 0) begin
        repeat (hold) begin @(posedge clk); #1; end
        chk("rpt_held", {31'd0, bus.rpt_valid}, 32'd1);
        chk("rpt_busy", {31'd0, bus.cmd_ready}, 32'd0);
        bus.rpt_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("rpt_done", {31'd0, bus.rpt_valid}, 32'd0);
      chk("rpt_idle", {31'd0, bus.cmd_ready}, 32'd1);
      bus.rpt_ready = 1'b0;
    end else begin
      busy = 0;
      while (!bus.cmd_ready && busy < 100) begin
        @(posedge clk); #1;
        busy++;
      end
      if ((t == SAVEDEC || t == RESTOREDEC) && q.size() == 1 && q[0] == 0) begin
        for (int i = 0; i < 8; i++) begin
          if (tbl_dec[i]) begin
            if (t == SAVEDEC) m_save[i] = m_mode[i];
            else              m_mode[i] = m_save[i];
          end
        end
      end else begin
        foreach (q[k]) begin
          ix = lookup(q[k], dec);
          if (ix >= 0) begin
            case (t)
              SETMODE, SETDEC:     m_mode[ix] = 1'b1;
              RESETMODE, RESETDEC: m_mode[ix] = 1'b0;
              SAVEDEC:             m_save[ix] = m_mode[ix];
              default:             m_mode[ix] = m_save[ix];
            endcase
          end
        end
      end
      chk("busy_cycles", 32'(busy), 32'(q.size()));
    end
    chk("mode_o", {24'd0, bus.mode_o}, {24'd0, m_mode});
    chk("pn_overflow", {31'd0, bus.pn_overflow}, {31'd0, ovf});
  endtask

  initial begin
    int pool [11] = '{0, 1, 4, 5, 6, 7, 12, 20, 25, 99, 3};
    commands_type_e fin;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = INIT_PN;
    bus.pn        = 8'd0;
    bus.rpt_ready = 1'b0;
    m_mode = 8'b0000_1110;
    m_save = 8'b0000_1110;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_mode", {24'd0, bus.mode_o}, 32'h0e);
    chk("reset_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("reset_rpt_valid", {31'd0, bus.rpt_valid}, 32'd0);
    chk("reset_ovf", {31'd0, bus.pn_overflow}, 32'd0);

    // Multi-Pn DEC reset
    sq.delete(); sq.push_back(6); sq.push_back(25); sq.push_back(7);
    run_seq(RESETDEC, 0);

    // ANSI 4 vs DEC 4
    sq.delete(); sq.push_back(4); run_seq(SETMODE, 0);
    chk("ansi4_set", {31'd0, bus.mode_o[4]}, 32'd1);
    sq.delete(); sq.push_back(4); run_seq(RESETDEC, 0);
    chk("dec4_ignored", {31'd0, bus.mode_o[4]}, 32'd1);
    sq.delete(); sq.push_back(4); run_seq(RESETMODE, 0);
    chk("ansi4_clear", {31'd0, bus.mode_o[4]}, 32'd0);

    // Overflow: 9 emits plus final
    sq.delete();
    repeat (9) sq.push_back(25);
    sq.push_back(6);
    run_seq(SETDEC, 0);

    // Save all / modify / restore all
    sq.delete(); sq.push_back(0); run_seq(SAVEDEC, 0);
    sq.delete(); sq.push_back(6); run_seq(SETDEC, 0);
    sq.delete(); sq.push_back(7); run_seq(RESETDEC, 0);
    sq.delete(); sq.push_back(0); run_seq(RESTOREDEC, 0);

    // Reports: held off, ready-early, unknown mode
    sq.delete(); sq.push_back(25); run_seq(REQDEC, 5);
    sq.delete(); sq.push_back(12); run_seq(REQDEC, 0);
    sq.delete(); sq.push_back(99); run_seq(REQMODE, 1);

    // Reset mid-APPLY restores defaults, including the save register
    sq.delete(); sq.push_back(6); run_seq(SETDEC, 0);
    sq.delete(); sq.push_back(0); run_seq(SAVEDEC, 0);
    send(INIT_PN, 0);
    send(EMIT_PN, 4);
    send(EMIT_PN, 20);
    send(SETMODE, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_mode = 8'b0000_1110;
    m_save = 8'b0000_1110;
    chk("midrst_mode", {24'd0, bus.mode_o}, 32'h0e);
    chk("midrst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("midrst_rpt", {31'd0, bus.rpt_valid}, 32'd0);
    sq.delete(); sq.push_back(6); run_seq(SETDEC, 0);
    sq.delete(); sq.push_back(0); run_seq(RESTOREDEC, 0);

    // Randomized sequences
    for (int n = 0; n < 60; n++) begin
      sq.delete();
      for (int j = 0; j <= int'($urandom_range(0, 10)); j++)
        sq.push_back(pool[$urandom_range(0, 10)]);
      fin = commands_type_e'(4'($urandom_range(2, 9)));
      run_seq(fin, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
